// File: rtl/raven_bus_pkg.sv
// Shared definitions for the raven 68000 bus glue: region codes, the
// A23..A20 address map and the bus-cycle responder state encoding.
`default_nettype none

package raven_bus_pkg;

  // Region of a bus cycle as reported on the region output.
  typedef enum logic [1:0] {
    REG_ROM  = 2'd0,
    REG_RAM  = 2'd1,
    REG_IO   = 2'd2,
    REG_NONE = 2'd3
  } region_e;

  // A23..A20 address map.
  localparam logic [3:0] MAP_ROM    = 4'h0;
  localparam logic [3:0] MAP_RAM_LO = 4'h1;
  localparam logic [3:0] MAP_RAM_HI = 4'h7;
  localparam logic [3:0] MAP_IO     = 4'hF;

  // Responder state encoding.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COUNT   = 3'd1;
  localparam logic [2:0] ST_ACK     = 3'd2;
  localparam logic [2:0] ST_BERR    = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_COUNT   = ST_COUNT,
    S_ACK     = ST_ACK,
    S_BERR    = ST_BERR,
    S_RELEASE = ST_RELEASE
  } state_e;

  // Map the top address nibble to a region.
  function automatic region_e decode_region(input logic [3:0] a);
    if (a == MAP_ROM) begin
      return REG_ROM;
    end else if ((a >= MAP_RAM_LO) && (a <= MAP_RAM_HI)) begin
      return REG_RAM;
    end else if (a == MAP_IO) begin
      return REG_IO;
    end else begin
      return REG_NONE;
    end
  endfunction

  // Decrement that holds at zero instead of wrapping.
  function automatic logic [3:0] dec_sat4(input logic [3:0] v);
    return (v == 4'd0) ? 4'd0 : (v - 4'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous, active-low bus strobe.
// Resets to 1 so a strobe reads as released while the system is in reset.
`default_nettype none

module sync_2ff (
  input  logic clk_in,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/bus_dtack_gen.sv
// 68000 bus-cycle responder. Watches AS/UDS/LDS, decodes the region from
// A23..A20 and answers with DTACK after the region's wait states (counted
// on cpu_clk falling edges) or with BERR on unmapped or stuck cycles.
`default_nettype none

module bus_dtack_gen
  import raven_bus_pkg::*;
#(
  parameter int unsigned ROM_WS  = 2,
  parameter int unsigned RAM_WS  = 0,
  parameter int unsigned IO_WS   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       cpu_clk,
  input  logic       as_n,
  input  logic       uds_n,
  input  logic       lds_n,
  input  logic [3:0] addr_hi,
  output logic       dtack_n,
  output logic       berr_n,
  output logic       bus_oe,
  output logic [1:0] region
);

  localparam int unsigned   TMO_W    = $clog2(TIMEOUT);
  localparam logic [3:0]    ROM_WS_C = 4'(ROM_WS);
  localparam logic [3:0]    RAM_WS_C = 4'(RAM_WS);
  localparam logic [3:0]    IO_WS_C  = 4'(IO_WS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  logic             as_s;
  logic             uds_s;
  logic             lds_s;
  logic             cpu_clk_q;
  logic             cpu_fall;
  state_e           state_q;
  region_e          region_q;
  region_e          region_d;
  logic [3:0]       wait_cnt_q;
  logic [3:0]       wait_cnt_d;
  logic [3:0]       ws_load;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic [TMO_W-1:0] tmo_cnt_d;
  logic             dtack_n_q;
  logic             berr_n_q;
  logic             bus_oe_q;
  logic             cycle_start;

  sync_2ff u_sync_as (
    .clk_in (clk_in),
    .reset  (reset),
    .d_i    (as_n),
    .q_o    (as_s)
  );

  sync_2ff u_sync_uds (
    .clk_in (clk_in),
    .reset  (reset),
    .d_i    (uds_n),
    .q_o    (uds_s)
  );

  sync_2ff u_sync_lds (
    .clk_in (clk_in),
    .reset  (reset),
    .d_i    (lds_n),
    .q_o    (lds_s)
  );

  // Remember last cpu_clk level so its falling edge can be detected.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cpu_clk_q <= 1'b0;
    end else begin
      cpu_clk_q <= cpu_clk;
    end
  end

  assign cpu_fall = cpu_clk_q & ~cpu_clk;

  // A cycle starts once AS and at least one data strobe are seen low.
  assign cycle_start = ~as_s & (~uds_s | ~lds_s);

  // Decode the region and pick its wait-state count for the counter load.
  always_comb begin
    region_d = decode_region(addr_hi);
    ws_load  = 4'd0;
    case (region_d)
      REG_ROM: ws_load = ROM_WS_C;
      REG_RAM: ws_load = RAM_WS_C;
      REG_IO:  ws_load = IO_WS_C;
      default: ws_load = 4'd0;
    endcase
  end

  // Counter step values for a cpu_clk falling edge that does not end the cycle.
  always_comb begin
    wait_cnt_d = dec_sat4(wait_cnt_q);
    tmo_cnt_d  = tmo_cnt_q;
    if (tmo_cnt_q != TMO_LAST) begin
      tmo_cnt_d = tmo_cnt_q + TMO_ONE;
    end
  end

  // Bus-cycle FSM with registered, glitch-free strobe and enable outputs.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= S_IDLE;
      region_q   <= REG_NONE;
      wait_cnt_q <= 4'd0;
      tmo_cnt_q  <= '0;
      dtack_n_q  <= 1'b1;
      berr_n_q   <= 1'b1;
      bus_oe_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          dtack_n_q <= 1'b1;
          berr_n_q  <= 1'b1;
          bus_oe_q  <= 1'b0;
          if (cycle_start) begin
            region_q   <= region_d;
            wait_cnt_q <= ws_load;
            tmo_cnt_q  <= '0;
            bus_oe_q   <= 1'b1;
            state_q    <= S_COUNT;
          end
        end

        S_COUNT: begin
          if (as_s) begin
            bus_oe_q <= 1'b0;
            state_q  <= S_IDLE;
          end else if (cpu_fall) begin
            if (tmo_cnt_q == TMO_LAST) begin
              berr_n_q <= 1'b0;
              state_q  <= S_BERR;
            end else if ((region_q != REG_NONE) && (wait_cnt_q == 4'd0)) begin
              dtack_n_q <= 1'b0;
              state_q   <= S_ACK;
            end else begin
              wait_cnt_q <= wait_cnt_d;
              tmo_cnt_q  <= tmo_cnt_d;
            end
          end
        end

        S_ACK: begin
          if (as_s) begin
            dtack_n_q <= 1'b1;
            state_q   <= S_RELEASE;
          end
        end

        S_BERR: begin
          if (as_s) begin
            berr_n_q <= 1'b1;
            state_q  <= S_RELEASE;
          end
        end

        S_RELEASE: begin
          dtack_n_q <= 1'b1;
          berr_n_q  <= 1'b1;
          bus_oe_q  <= 1'b0;
          state_q   <= S_IDLE;
        end

        default: begin
          dtack_n_q <= 1'b1;
          berr_n_q  <= 1'b1;
          bus_oe_q  <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign dtack_n = dtack_n_q;
  assign berr_n  = berr_n_q;
  assign bus_oe  = bus_oe_q;
  assign region  = region_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_dtack_gen.sv
// Directed bench for bus_dtack_gen: RAM/ROM/IO acknowledge timing,
// unmapped-cycle bus error, abort, write strobe delay and reset during ACK.
`timescale 1ns/1ps

module tb_bus_dtack_gen;

  logic       clk_in  = 1'b0;
  logic       reset   = 1'b1;
  logic       cpu_clk = 1'b0;
  logic       as_n    = 1'b1;
  logic       uds_n   = 1'b1;
  logic       lds_n   = 1'b1;
  logic [3:0] addr_hi = 4'h0;
  logic       dtack_n;
  logic       berr_n;
  logic       bus_oe;
  logic [1:0] region;

  int   checkCnt = 0;
  int   passCnt  = 0;
  int   fallCnt  = 0;
  logic cpuPrev  = 1'b0;
  bit   sawDtackLow = 0;
  bit   sawBerrLow  = 0;
  bit   sawOe       = 0;

  bus_dtack_gen #(
    .ROM_WS  (2),
    .RAM_WS  (0),
    .IO_WS   (4),
    .TIMEOUT (64)
  ) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .cpu_clk (cpu_clk),
    .as_n    (as_n),
    .uds_n   (uds_n),
    .lds_n   (lds_n),
    .addr_hi (addr_hi),
    .dtack_n (dtack_n),
    .berr_n  (berr_n),
    .bus_oe  (bus_oe),
    .region  (region)
  );

  // 50MHz system clock.
  initial begin
    forever #10 clk_in = ~clk_in;
  end

  // 5MHz CPU clock, toggled shortly after every fifth system clock edge.
  initial begin
    forever begin
      repeat (5) @(posedge clk_in);
      #1 cpu_clk = ~cpu_clk;
    end
  end

  // Count the system clock edges on which cpu_clk is seen freshly low.
  always @(posedge clk_in) begin
    cpuPrev <= cpu_clk;
    if (cpuPrev && !cpu_clk) fallCnt <= fallCnt + 1;
  end

  // Remember whether any strobe or the output enable was seen active.
  always @(negedge clk_in) begin
    if (dtack_n === 1'b0) sawDtackLow = 1;
    if (berr_n === 1'b0)  sawBerrLow  = 1;
    if (bus_oe === 1'b1)  sawOe       = 1;
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic sigSel(input int sel);
    case (sel)
      0:       return bus_oe;
      1:       return dtack_n;
      default: return berr_n;
    endcase
  endfunction

  task automatic waitSig(input int sel, input logic level, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (sigSel(sel) === level) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    checkCnt++; if (dtack_n !== 1'b1) $display("[TB] FAIL reset_dtack: got %b want 1", dtack_n); else passCnt++;
    checkCnt++; if (berr_n !== 1'b1)  $display("[TB] FAIL reset_berr: got %b want 1", berr_n); else passCnt++;
    checkCnt++; if (bus_oe !== 1'b0)  $display("[TB] FAIL reset_oe: got %b want 0", bus_oe); else passCnt++;
    checkCnt++; if (region !== 2'd3)  $display("[TB] FAIL reset_region: got %0d want 3", region); else passCnt++;
    reset = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_ram_read();
    bit ok;
    int f0;
    addr_hi = 4'h2; as_n = 1'b0; lds_n = 1'b0;
    waitSig(0, 1'b1, 10, ok);
    f0 = fallCnt;
    checkCnt++; if (!ok) $display("[TB] FAIL ram_start: bus_oe got %b want 1 within 10 cycles", bus_oe); else passCnt++;
    checkCnt++; if (region !== 2'd1) $display("[TB] FAIL ram_region: got %0d want 1", region); else passCnt++;
    waitSig(1, 1'b0, 40, ok);
    checkCnt++; if (!ok) $display("[TB] FAIL ram_ack: dtack_n got %b want 0 within 40 cycles", dtack_n); else passCnt++;
    checkCnt++; if (fallCnt !== f0 + 1) $display("[TB] FAIL ram_ack_fall: got fall %0d want %0d", fallCnt - f0, 1); else passCnt++;
    as_n = 1'b1; lds_n = 1'b1;
    waitSig(1, 1'b1, 10, ok);
    checkCnt++; if (!ok) $display("[TB] FAIL ram_dtack_release: dtack_n got %b want 1", dtack_n); else passCnt++;
    checkCnt++; if (bus_oe !== 1'b1) $display("[TB] FAIL ram_release_oe: got %b want 1", bus_oe); else passCnt++;
    step();
    checkCnt++; if (bus_oe !== 1'b0) $display("[TB] FAIL ram_idle_oe: got %b want 0", bus_oe); else passCnt++;
    repeat (4) step();
  endtask

  task automatic test_rom();
    bit ok;
    int f0;
    addr_hi = 4'h0; as_n = 1'b0; uds_n = 1'b0;
    waitSig(0, 1'b1, 10, ok);
    f0 = fallCnt;
    checkCnt++; if (region !== 2'd0) $display("[TB] FAIL rom_region: got %0d want 0", region); else passCnt++;
    waitSig(1, 1'b0, 60, ok);
    checkCnt++; if (!ok) $display("[TB] FAIL rom_ack: dtack_n got %b want 0 within 60 cycles", dtack_n); else passCnt++;
    checkCnt++; if (fallCnt !== f0 + 3) $display("[TB] FAIL rom_ack_fall: got fall %0d want 3", fallCnt - f0); else passCnt++;
    checkCnt++; if (region !== 2'd0) $display("[TB] FAIL rom_region_hold: got %0d want 0", region); else passCnt++;
    as_n = 1'b1; uds_n = 1'b1;
    repeat (6) step();
  endtask

  task automatic test_io_ack();
    bit ok;
    int f0;
    addr_hi = 4'hF; as_n = 1'b0; lds_n = 1'b0; uds_n = 1'b0;
    waitSig(0, 1'b1, 10, ok);
    f0 = fallCnt;
    checkCnt++; if (region !== 2'd2) $display("[TB] FAIL io_region: got %0d want 2", region); else passCnt++;
    waitSig(1, 1'b0, 80, ok);
    checkCnt++; if (fallCnt !== f0 + 5) $display("[TB] FAIL io_ack_fall: got fall %0d want 5", fallCnt - f0); else passCnt++;
    as_n = 1'b1; lds_n = 1'b1; uds_n = 1'b1;
    repeat (6) step();
  endtask

  task automatic test_unmapped();
    bit ok;
    int f0;
    addr_hi = 4'h9; as_n = 1'b0; lds_n = 1'b0;
    waitSig(0, 1'b1, 10, ok);
    f0 = fallCnt;
    sawDtackLow = 0;
    checkCnt++; if (region !== 2'd3) $display("[TB] FAIL unmapped_region: got %0d want 3", region); else passCnt++;
    waitSig(2, 1'b0, 700, ok);
    checkCnt++; if (!ok) $display("[TB] FAIL unmapped_berr: berr_n got %b want 0 within 700 cycles", berr_n); else passCnt++;
    checkCnt++; if (fallCnt !== f0 + 64) $display("[TB] FAIL unmapped_berr_fall: got fall %0d want 64", fallCnt - f0); else passCnt++;
    checkCnt++; if (sawDtackLow !== 1'b0) $display("[TB] FAIL unmapped_dtack: dtack_n went low, want stays 1"); else passCnt++;
    as_n = 1'b1; lds_n = 1'b1;
    waitSig(2, 1'b1, 10, ok);
    checkCnt++; if (bus_oe !== 1'b1) $display("[TB] FAIL unmapped_release_oe: got %b want 1", bus_oe); else passCnt++;
    step();
    checkCnt++; if (bus_oe !== 1'b0) $display("[TB] FAIL unmapped_idle_oe: got %b want 0", bus_oe); else passCnt++;
    repeat (4) step();
  endtask

  task automatic test_abort();
    bit ok;
    int f0;
    addr_hi = 4'hF; as_n = 1'b0; lds_n = 1'b0;
    waitSig(0, 1'b1, 10, ok);
    f0 = fallCnt;
    sawDtackLow = 0; sawBerrLow = 0;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (fallCnt >= f0 + 2) begin
        ok = 1;
        break;
      end
    end
    checkCnt++; if (!ok) $display("[TB] FAIL abort_falls: got %0d falls want 2 within 40 cycles", fallCnt - f0); else passCnt++;
    as_n = 1'b1; lds_n = 1'b1;
    repeat (3) step();
    checkCnt++; if (bus_oe !== 1'b0) $display("[TB] FAIL abort_oe: got %b want 0 after 3 cycles", bus_oe); else passCnt++;
    checkCnt++; if ((sawDtackLow | sawBerrLow) !== 1'b0)
      $display("[TB] FAIL abort_strobes: dtack low %b berr low %b want 0 0", sawDtackLow, sawBerrLow); else passCnt++;
    repeat (4) step();
  endtask

  task automatic test_write_delay();
    bit ok;
    int f0;
    int s0;
    addr_hi = 4'h3; as_n = 1'b0;
    sawOe = 0;
    s0 = fallCnt;
    for (int i = 0; i < 150; i++) begin
      step();
      if (fallCnt >= s0 + 10) break;
    end
    checkCnt++; if (sawOe !== 1'b0) $display("[TB] FAIL write_wait_idle: bus_oe rose with no data strobe, want 0"); else passCnt++;
    uds_n = 1'b0;
    waitSig(0, 1'b1, 10, ok);
    f0 = fallCnt;
    checkCnt++; if (!ok) $display("[TB] FAIL write_start: bus_oe got %b want 1 within 10 cycles", bus_oe); else passCnt++;
    waitSig(1, 1'b0, 40, ok);
    checkCnt++; if (fallCnt !== f0 + 1) $display("[TB] FAIL write_ack_fall: got fall %0d want 1", fallCnt - f0); else passCnt++;
    checkCnt++; if (region !== 2'd1) $display("[TB] FAIL write_region: got %0d want 1", region); else passCnt++;
    as_n = 1'b1; uds_n = 1'b1;
    repeat (6) step();
  endtask

  task automatic test_reset_during_ack();
    bit ok;
    addr_hi = 4'h5; as_n = 1'b0; lds_n = 1'b0;
    waitSig(1, 1'b0, 60, ok);
    checkCnt++; if (!ok) $display("[TB] FAIL rst_ack_reach: dtack_n got %b want 0 within 60 cycles", dtack_n); else passCnt++;
    reset = 1'b1;
    step();
    checkCnt++; if (dtack_n !== 1'b1) $display("[TB] FAIL rst_ack_dtack: got %b want 1", dtack_n); else passCnt++;
    checkCnt++; if (bus_oe !== 1'b0)  $display("[TB] FAIL rst_ack_oe: got %b want 0", bus_oe); else passCnt++;
    checkCnt++; if (region !== 2'd3)  $display("[TB] FAIL rst_ack_region: got %0d want 3", region); else passCnt++;
    reset = 1'b0; as_n = 1'b1; lds_n = 1'b1;
    sawOe = 0;
    repeat (6) step();
    checkCnt++; if (sawOe !== 1'b0) $display("[TB] FAIL rst_ack_idle: bus_oe rose after reset, want 0"); else passCnt++;
  endtask

  initial begin
    test_reset();
    test_ram_read();
    test_rom();
    test_io_ack();
    test_unmapped();
    test_abort();
    test_write_delay();
    test_reset_during_ack();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
